// File: rtl/btn_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_ctrl : per-channel sync + debounce, press/release W1C flags, masked irq |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module btn_ctrl #(
  parameter int BTN_NUM         = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BTN_NUM-1:0] btn,
  input  logic               enabler,
  input  logic               write_enabler,
  input  logic [31:0]        addr,
  input  logic [3:0]         select,
  input  logic [31:0]        data_input,
  output logic [31:0]        data_output,
  output logic               irq
);

  localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       REG_STATE = 2'd0;
  localparam logic [1:0]       REG_PRESS = 2'd1;
  localparam logic [1:0]       REG_REL   = 2'd2;
  localparam logic [1:0]       REG_MASK  = 2'd3;

  logic [SYNC_STAGES-1:0][BTN_NUM-1:0] sync_q, sync_d;
  logic [BTN_NUM-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [BTN_NUM-1:0]                  deb_q, deb_d;
  logic [BTN_NUM-1:0]                  press_q, press_d;
  logic [BTN_NUM-1:0]                  rel_q, rel_d;
  logic [BTN_NUM-1:0]                  mask_q, mask_d;
  logic                                irq_q, irq_d;

  logic [BTN_NUM-1:0] sampled;
  logic [BTN_NUM-1:0] rise;
  logic [BTN_NUM-1:0] fall;
  logic [BTN_NUM-1:0] lane_en;
  logic [BTN_NUM-1:0] wr_bits;
  logic [BTN_NUM-1:0] w1c_press;
  logic [BTN_NUM-1:0] w1c_rel;
  logic [BTN_NUM-1:0] rd_bits;
  logic               wr_acc;
  logic               unused_ok;

  assign sampled   = sync_q[SYNC_STAGES-1];
  assign wr_acc    = enabler & write_enabler;
  assign wr_bits   = data_input[BTN_NUM-1:0];
  assign unused_ok = ^{addr[31:4], addr[1:0], data_input, select};

  // Synchronizer shift and per-channel debounce counter
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < BTN_NUM; i++) begin
      if (sampled[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = sampled[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;
  end

  // Bus writes: byte-lane gating, W1C flags where a new edge event wins
  always_comb begin
    lane_en = '0;
    for (int i = 0; i < BTN_NUM; i++) begin
      lane_en[i] = select[i / 8];
    end
    w1c_press = '0;
    w1c_rel   = '0;
    mask_d    = mask_q;
    if (wr_acc) begin
      case (addr[3:2])
        REG_PRESS: w1c_press = wr_bits & lane_en;
        REG_REL:   w1c_rel   = wr_bits & lane_en;
        REG_MASK:  mask_d    = (mask_q & ~lane_en) | (wr_bits & lane_en);
        default:   ;
      endcase
    end
    press_d = (press_q & ~w1c_press) | rise;
    rel_d   = (rel_q & ~w1c_rel) | fall;
    irq_d   = |(press_q & mask_q);
  end

  always_comb begin
    rd_bits = '0;
    if (enabler && !write_enabler) begin
      case (addr[3:2])
        REG_STATE: rd_bits = deb_q;
        REG_PRESS: rd_bits = press_q;
        REG_REL:   rd_bits = rel_q;
        default:   rd_bits = mask_q;
      endcase
    end
    data_output = {{(32 - BTN_NUM){1'b0}}, rd_bits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
`default_nettype wire

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter BTN_NUM, default 5, number of button channels (legal 1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, number of consecutive stable cycles required to accept a level change (legal >= 2).
REQ-003 Parameter SYNC_STAGES, default 2, number of synchronizer flops per channel (legal >= 2).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn  input  BTN_NUM  raw asynchronous button levels, 1 = pressed.
REQ-007 enabler  input  1  block selected for the current bus access.
REQ-008 write_enabler  input  1  access is a write when enabler=1.
REQ-009 addr  input  32  byte address; only addr[3:2] are decoded.
REQ-010 select  input  4  byte-lane write enables; bit i gates data_input[8i+7:8i].
REQ-011 data_input  input  32  write data.
REQ-012 data_output  output  32  read data.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 Each channel SHALL pass btn through a SYNC_STAGES-deep flop chain; the last stage is the sampled level s.
REQ-015 Each channel SHALL keep a debounced level d and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-016 If s == d, the counter SHALL clear to 0.
REQ-017 If s != d and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-018 If s != d and counter == DEBOUNCE_CYCLES-1, d SHALL take s and the counter SHALL clear on that edge; the counter never wraps.
REQ-019 A btn change held stable SHALL appear on d exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after it is first captured; any shorter glitch SHALL leave d unchanged.
REQ-020 Register map on addr[3:2]: 0 STATE (d, read-only), 1 PRESS (sticky rising-edge flags, W1C), 2 RELEASE (sticky falling-edge flags, W1C), 3 MASK (read/write interrupt mask).
REQ-021 PRESS[i] SHALL set on the same edge d[i] goes 0->1; RELEASE[i] SHALL set on the same edge d[i] goes 1->0.
REQ-022 A write (enabler=1, write_enabler=1) to PRESS/RELEASE SHALL clear each bit i where data_input[i]=1 and select[i/8]=1.
REQ-023 If a set event and a W1C clear hit the same bit on the same edge, set SHALL win (bit = 1).
REQ-024 A write to MASK SHALL update only bits in enabled byte lanes; bits >= BTN_NUM are not stored.
REQ-025 Writes to STATE SHALL be ignored; writes with enabler=0 or select=0000 SHALL change nothing.
REQ-026 data_output SHALL be combinational: selected register zero-extended when enabler=1 and write_enabler=0, otherwise 32'h0; bits >= BTN_NUM always read 0.
REQ-027 irq SHALL be registered: irq <= |(PRESS & MASK) using the post-update PRESS value, i.e. one edge after the PRESS change.
REQ-028 RELEASE SHALL not contribute to irq.

Reset
REQ-029 While rst=1, synchronizers, d, counters, PRESS, RELEASE, MASK and irq SHALL be 0, asynchronously and irrespective of clk.
REQ-030 Reset during a debounce count SHALL abandon the count; after release a held button SHALL need the full SYNC_STAGES+DEBOUNCE_CYCLES again and SHALL then set PRESS.

Verification (bench: BTN_NUM=5, DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 Bounce: btn=5'b00001 for 3 cycles then 0 -> STATE reads 0, PRESS reads 0, irq=0 throughout.
REQ-032 Stable press: btn=5'b00001 held -> STATE=32'h1 exactly 6 edges after first capture, PRESS=32'h1, irq=0; write MASK=32'h1 with select=4'b0001 -> irq=1 one edge after the write.
REQ-033 W1C: write PRESS data 32'h1 with select=4'b0000 -> PRESS stays 32'h1; repeat with select=4'b0001 -> PRESS=0, irq=0 one edge later.
REQ-034 Collision: schedule a W1C of PRESS[1] on the edge d[1] rises -> PRESS[1]=1 afterwards.
REQ-035 Release all: btn 5'b11111 -> 5'b00000 after acceptance -> RELEASE=32'h1F, STATE=0, irq unaffected by RELEASE.
REQ-036 Mid-count reset: assert rst at counter=2 with btn[0] held -> all outputs and registers 0 immediately; after deassert STATE[0]=1 only after 6 more edges.
